sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 3, max consecutive data grants while inst_req pending (range 0..15).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inst_req  input  1  fetch request; held with inst_addr stable until inst_gnt.
REQ-005 inst_addr  input  32  fetch byte address.
REQ-006 inst_gnt  output  1  fetch accepted this cycle.
REQ-007 inst_rvalid  output  1  fetch data valid.
REQ-008 inst_rdata  output  32  fetch data.
REQ-009 data_req  input  1  load/store request; held with data_wen/addr/wdata stable until data_gnt.
REQ-010 data_wen  input  8  byte write enables; 0 = read.
REQ-011 data_addr  input  32  data byte address.
REQ-012 data_wdata  input  64  store data.
REQ-013 data_gnt  output  1  data request accepted this cycle.
REQ-014 data_rvalid  output  1  data response (read data or write ack).
REQ-015 data_rdata  output  64  load data.
REQ-016 sram_en  output  1  shared SRAM port enable.
REQ-017 sram_wen  output  8  shared SRAM byte write enables.
REQ-018 sram_addr  output  32  shared SRAM address.
REQ-019 sram_wdata  output  64  shared SRAM write data.
REQ-020 sram_rdata  input  64  SRAM read data, valid one cycle after sram_en.

Function
REQ-021 Grant combinational in cycle N; at most one grant per cycle; sram_en = inst_gnt | data_gnt.
REQ-022 Data grant: sram_wen=data_wen, sram_addr=data_addr, sram_wdata=data_wdata; inst grant: sram_wen=0, sram_addr=inst_addr, sram_wdata=0; no grant: sram_en=0, sram_wen=0, sram_addr/sram_wdata=0.
REQ-023 Sole requester is granted in the cycle it requests.
REQ-024 Conflict (both req): data wins unless starve_cnt >= STARVE_MAX, then inst wins.
REQ-025 starve_cnt (4-bit): +1 (saturate at 15) on data_gnt with inst_req high; cleared on inst_gnt or inst_req low.
REQ-026 Response-owner FSM, states IDLE, INST, DATA: next state = INST on inst_gnt, DATA on data_gnt, else IDLE; every state transitions each cycle (no wait states).
REQ-027 Owner INST: inst_rvalid=1 in cycle N+1, inst_rdata = sram_rdata[63:32] if registered inst_addr[2]=1, else sram_rdata[31:0].
REQ-028 Owner DATA: data_rvalid=1 in cycle N+1 for reads and writes; data_rdata=sram_rdata (don't-care for writes).
REQ-029 Read latency exactly 1 cycle; back-to-back grants every cycle supported; responses in grant order.
REQ-030 Non-owner rvalid=0 and its rdata=0.
REQ-031 Grant outputs depend only on current req inputs and starve_cnt, never on rvalid.

Reset
REQ-032 reset high: inst_gnt=0, data_gnt=0, sram_en=0 combinationally regardless of requests.
REQ-033 After reset edge: FSM=IDLE, starve_cnt=0, registered addr bit=0, inst_rvalid=0, data_rvalid=0.
REQ-034 Reset in cycle N+1 of a grant: that response suppressed (rvalid=0 after reset edge); no response emitted later.

Verification
REQ-035 Inst-only: inst_req=1, inst_addr=0x80000004, sram_rdata=0x11112222_33334444 next cycle -> inst_gnt cycle N, inst_rvalid N+1, inst_rdata=0x11112222.
REQ-036 Data write: data_req=1, data_wen=0x0F, data_addr=0x100, data_wdata=0xAABBCCDD -> sram_en=1, sram_wen=0x0F, sram_addr=0x100 cycle N; data_rvalid=1 N+1.
REQ-037 Conflict, STARVE_MAX=3, both held high -> grants D,D,D,I, then repeats; starve_cnt 0,1,2,3,0.
REQ-038 STARVE_MAX=0, both held high -> inst granted every cycle; data_gnt=0 until inst_req drops.
REQ-039 Alternating single-cycle requests I,D,I every cycle -> rvalid alternates inst,data,inst one cycle later, correct data routing.
REQ-040 Grant at N, reset at N+1 -> no rvalid at N+1 or later; sram_en=0 during reset; starve_cnt=0 after.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
// Bundles the two requester ports (instruction fetch, load/store) and the
// shared single-port SRAM bus.
//   slave  : arbiter view (takes requests and SRAM read data, drives grants,
//            responses and the SRAM command)
//   master : environment view (requesters plus SRAM model)
interface sram_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic [7:0]  data_wen;
  logic [31:0] data_addr;
  logic [63:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [63:0] data_rdata;

  logic        sram_en;
  logic [7:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wen, data_addr, data_wdata,
    input  sram_rdata,
    output inst_gnt, inst_rvalid, inst_rdata,
    output data_gnt, data_rvalid, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wen, data_addr, data_wdata,
    output sram_rdata,
    input  inst_gnt, inst_rvalid, inst_rdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one 64-bit SRAM port between an instruction fetch port and a
// load/store port. Grants are combinational; the data port has priority
// except when the fetch port has lost STARVE_MAX consecutive conflicts.
// Responses come back exactly one cycle after the grant, routed by a
// small response-owner FSM.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset (also masks grants and responses)
//   bus   : sram_port_arbiter_if.slave (requesters + SRAM bus)
//
// state  | meaning
// S_IDLE | no SRAM response expected this cycle
// S_INST | SRAM read data this cycle belongs to the fetch port
// S_DATA | SRAM response this cycle belongs to the load/store port
module sram_port_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input logic             clk_i,
  input logic             rst_i,
  sram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_INST, S_DATA} state_t;

  state_t     state_q;
  logic [3:0] starve_q, starve_d;
  logic       addr2_q;

  logic inst_gnt, data_gnt;
  logic inst_rv, data_rv;
  logic starved;

  assign starved = (starve_q >= 4'(STARVE_MAX));

  // Fetch wins a conflict only once it has been starved long enough.
  assign inst_gnt = ~rst_i & bus.inst_req & (~bus.data_req | starved);
  assign data_gnt = ~rst_i & bus.data_req & (~bus.inst_req | ~starved);

  always_comb begin
    starve_d = starve_q;
    if (inst_gnt || !bus.inst_req)
      starve_d = 4'd0;
    else if (data_gnt && starve_q != 4'hF)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      starve_q <= 4'd0;
      addr2_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      if (inst_gnt)
        addr2_q <= bus.inst_addr[2];
      case (state_q)
        S_IDLE, S_INST, S_DATA: begin
          if (inst_gnt)      state_q <= S_INST;
          else if (data_gnt) state_q <= S_DATA;
          else               state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Masking with rst_i drops a response whose cycle coincides with reset.
  assign inst_rv = (state_q == S_INST) & ~rst_i;
  assign data_rv = (state_q == S_DATA) & ~rst_i;

  assign bus.inst_gnt    = inst_gnt;
  assign bus.data_gnt    = data_gnt;
  assign bus.inst_rvalid = inst_rv;
  assign bus.data_rvalid = data_rv;
  assign bus.inst_rdata  = inst_rv ? (addr2_q ? bus.sram_rdata[63:32]
                                              : bus.sram_rdata[31:0])
                                   : 32'd0;
  assign bus.data_rdata  = data_rv ? bus.sram_rdata : 64'd0;

  always_comb begin
    bus.sram_en    = inst_gnt | data_gnt;
    bus.sram_wen   = 8'd0;
    bus.sram_addr  = 32'd0;
    bus.sram_wdata = 64'd0;
    if (data_gnt) begin
      bus.sram_wen   = bus.data_wen;
      bus.sram_addr  = bus.data_addr;
      bus.sram_wdata = bus.data_wdata;
    end else if (inst_gnt) begin
      bus.sram_addr  = bus.inst_addr;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Directed bench for sram_port_arbiter: dut0 uses STARVE_MAX=3, dut1 uses
// STARVE_MAX=0. Inputs change 1 time unit after the rising edge, outputs
// are sampled on the falling edge.
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sram_port_arbiter_if if0();
  sram_port_arbiter_if if1();

  sram_port_arbiter #(.STARVE_MAX(3)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
  sram_port_arbiter #(.STARVE_MAX(0)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle0();
    if0.inst_req = 1'b0; if0.inst_addr = 32'd0;
    if0.data_req = 1'b0; if0.data_wen = 8'd0; if0.data_addr = 32'd0;
    if0.data_wdata = 64'd0; if0.sram_rdata = 64'd0;
  endtask

  task automatic idle1();
    if1.inst_req = 1'b0; if1.inst_addr = 32'd0;
    if1.data_req = 1'b0; if1.data_wen = 8'd0; if1.data_addr = 32'd0;
    if1.data_wdata = 64'd0; if1.sram_rdata = 64'd0;
  endtask

  // Both ports requesting on dut0 for n cycles; inst wins every 4th.
  task automatic conflict_run(input int n, input string tag);
    logic exp_i;
    logic prev_i;
    prev_i = 1'b0;
    if0.inst_req = 1'b1; if0.inst_addr = 32'h0000_0004;
    if0.data_req = 1'b1; if0.data_wen = 8'h00; if0.data_addr = 32'h0000_0040;
    for (int i = 0; i < n; i++) begin
      exp_i = ((i % 4) == 3);
      samp();
      chk({tag, "_ign"}, 64'(if0.inst_gnt), 64'(exp_i));
      chk({tag, "_dgn"}, 64'(if0.data_gnt), 64'(!exp_i));
      if (i > 0) chk({tag, "_irv"}, 64'(if0.inst_rvalid), 64'(prev_i));
      prev_i = exp_i;
      next_cyc();
    end
  endtask

  initial begin
    idle0(); idle1();
    rst = 1'b1;
    if0.inst_req = 1'b1; if0.data_req = 1'b1;
    samp();
    chk("rst_ign", 64'(if0.inst_gnt), 64'd0);
    chk("rst_dgn", 64'(if0.data_gnt), 64'd0);
    chk("rst_en",  64'(if0.sram_en),  64'd0);
    next_cyc();
    samp();
    chk("rst_irv", 64'(if0.inst_rvalid), 64'd0);
    chk("rst_drv", 64'(if0.data_rvalid), 64'd0);
    next_cyc();
    rst = 1'b0; idle0();
    samp();
    chk("idle_en",   64'(if0.sram_en),   64'd0);
    chk("idle_addr", 64'(if0.sram_addr), 64'd0);
    chk("idle_irv",  64'(if0.inst_rvalid), 64'd0);

    // inst-only fetch of upper word
    next_cyc();
    if0.inst_req = 1'b1; if0.inst_addr = 32'h8000_0004;
    samp();
    chk("io_ign",  64'(if0.inst_gnt),  64'd1);
    chk("io_dgn",  64'(if0.data_gnt),  64'd0);
    chk("io_en",   64'(if0.sram_en),   64'd1);
    chk("io_addr", 64'(if0.sram_addr), 64'h8000_0004);
    chk("io_wen",  64'(if0.sram_wen),  64'd0);
    chk("io_wd",   if0.sram_wdata,     64'd0);
    next_cyc();
    if0.inst_req = 1'b0; if0.sram_rdata = 64'h1111_2222_3333_4444;
    samp();
    chk("io_irv",   64'(if0.inst_rvalid), 64'd1);
    chk("io_rdata", 64'(if0.inst_rdata),  64'h1111_2222);
    chk("io_drv",   64'(if0.data_rvalid), 64'd0);
    chk("io_drd",   if0.data_rdata,       64'd0);
    chk("io_en2",   64'(if0.sram_en),     64'd0);

    // data write
    next_cyc();
    idle0();
    if0.data_req = 1'b1; if0.data_wen = 8'h0F; if0.data_addr = 32'h100;
    if0.data_wdata = 64'hAABB_CCDD;
    samp();
    chk("dw_dgn",  64'(if0.data_gnt),  64'd1);
    chk("dw_ign",  64'(if0.inst_gnt),  64'd0);
    chk("dw_en",   64'(if0.sram_en),   64'd1);
    chk("dw_wen",  64'(if0.sram_wen),  64'h0F);
    chk("dw_addr", 64'(if0.sram_addr), 64'h100);
    chk("dw_wd",   if0.sram_wdata,     64'hAABB_CCDD);
    next_cyc();
    idle0();
    samp();
    chk("dw_drv", 64'(if0.data_rvalid), 64'd1);
    chk("dw_irv", 64'(if0.inst_rvalid), 64'd0);
    chk("dw_ird", 64'(if0.inst_rdata),  64'd0);

    // alternating I, D, I with one-cycle responses
    next_cyc();
    if0.inst_req = 1'b1; if0.inst_addr = 32'h0000_0004;
    samp();
    chk("alt1_ign", 64'(if0.inst_gnt), 64'd1);
    next_cyc();
    if0.inst_req = 1'b0;
    if0.data_req = 1'b1; if0.data_wen = 8'h00; if0.data_addr = 32'h200;
    if0.sram_rdata = 64'hCAFE_BABE_DEAD_BEEF;
    samp();
    chk("alt2_dgn", 64'(if0.data_gnt),    64'd1);
    chk("alt2_dwen",64'(if0.sram_wen),    64'd0);
    chk("alt2_irv", 64'(if0.inst_rvalid), 64'd1);
    chk("alt2_ird", 64'(if0.inst_rdata),  64'hCAFE_BABE);
    chk("alt2_drv", 64'(if0.data_rvalid), 64'd0);
    next_cyc();
    if0.data_req = 1'b0;
    if0.inst_req = 1'b1; if0.inst_addr = 32'h0000_0008;
    if0.sram_rdata = 64'h0123_4567_89AB_CDEF;
    samp();
    chk("alt3_ign", 64'(if0.inst_gnt),    64'd1);
    chk("alt3_drv", 64'(if0.data_rvalid), 64'd1);
    chk("alt3_drd", if0.data_rdata,       64'h0123_4567_89AB_CDEF);
    chk("alt3_irv", 64'(if0.inst_rvalid), 64'd0);
    chk("alt3_ird", 64'(if0.inst_rdata),  64'd0);
    next_cyc();
    if0.inst_req = 1'b0;
    if0.sram_rdata = 64'hFEDC_BA98_7654_3210;
    samp();
    chk("alt4_irv", 64'(if0.inst_rvalid), 64'd1);
    chk("alt4_ird", 64'(if0.inst_rdata),  64'h7654_3210);
    chk("alt4_drv", 64'(if0.data_rvalid), 64'd0);

    // conflict with STARVE_MAX=3: D,D,D,I repeating
    next_cyc();
    idle0();
    conflict_run(8, "cf");
    idle0();

    // STARVE_MAX=0 on dut1: inst always wins
    if1.inst_req = 1'b1; if1.inst_addr = 32'h40;
    if1.data_req = 1'b1; if1.data_addr = 32'h80;
    for (int i = 0; i < 3; i++) begin
      samp();
      chk("s0_ign", 64'(if1.inst_gnt), 64'd1);
      chk("s0_dgn", 64'(if1.data_gnt), 64'd0);
      next_cyc();
    end
    if1.inst_req = 1'b0;
    samp();
    chk("s0_dgn_drop", 64'(if1.data_gnt), 64'd1);
    chk("s0_addr",     64'(if1.sram_addr), 64'h80);
    next_cyc();
    idle1();

    // reset one cycle after a grant, with starve count built up
    if0.inst_req = 1'b1; if0.data_req = 1'b1;
    samp();
    chk("rs_d1", 64'(if0.data_gnt), 64'd1);
    next_cyc();
    samp();
    chk("rs_d2", 64'(if0.data_gnt), 64'd1);
    next_cyc();
    rst = 1'b1;
    if0.sram_rdata = 64'h5555_6666_7777_8888;
    samp();
    chk("rs_drv",  64'(if0.data_rvalid), 64'd0);
    chk("rs_drd",  if0.data_rdata,       64'd0);
    chk("rs_en",   64'(if0.sram_en),     64'd0);
    chk("rs_ign",  64'(if0.inst_gnt),    64'd0);
    chk("rs_dgn",  64'(if0.data_gnt),    64'd0);
    next_cyc();
    rst = 1'b0; idle0();
    samp();
    chk("rs_drv2", 64'(if0.data_rvalid), 64'd0);
    chk("rs_irv2", 64'(if0.inst_rvalid), 64'd0);
    next_cyc();
    samp();
    chk("rs_drv3", 64'(if0.data_rvalid), 64'd0);
    next_cyc();
    // starve count restarted from 0: D,D,D,I again
    conflict_run(4, "rc");
    idle0();
    next_cyc();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
